// File: rtl/spi_ctrl_writer.sv
// spi_ctrl_writer
// SPI mode-0, MSB-first controller that sends 16-bit register-write frames
// {rw, addr[6:0], data[7:0]} to the onboarding SPI peripheral.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   req_valid  request present
//   req_ready  request accepted when high together with req_valid (IDLE only)
//   req_rw     frame bit 15
//   req_addr   frame bits 14:8
//   req_data   frame bits 7:0
//   ncs        chip select, active low
//   sclk       serial clock, idles low
//   copi       serial data toward the peripheral
//   busy       high whenever the FSM is not in IDLE
//   done       one-cycle pulse when a frame completes
//
// Every output comes straight from a flop, so nothing on the request side
// reaches the pins combinationally.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ncs high, waiting for a request
// SETUP | ncs low, first bit on copi, one half-period before first rise
// SHIFT | sclk toggling; shift on each fall, 16 falls in total
// HOLD  | ncs low, sclk low for one half-period after the last fall
// GAP   | ncs high for two half-periods before accepting again

module spi_ctrl_writer #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       ncs,
  output logic       sclk,
  output logic       copi,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  // 9 bits covers the GAP length of 2*255 cycles.
  localparam logic [8:0] HALF_TC = 9'(CLK_DIV - 1);
  localparam logic [8:0] GAP_TC  = 9'(2 * CLK_DIV - 1);

  logic [2:0]  r_state;
  logic [8:0]  r_div;
  logic [4:0]  r_bits;
  // Bit 15 of the frame goes straight onto copi at the handshake, so only
  // the remaining 15 bits need storing.
  logic [14:0] r_shift;
  logic        r_ncs;
  logic        r_sclk;
  logic        r_copi;
  logic        r_ready;
  logic        r_busy;
  logic        r_done;

  logic        w_tc;

  assign w_tc = (r_div == ((r_state == S_GAP) ? GAP_TC : HALF_TC));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bits  <= '0;
      r_shift <= '0;
      r_ncs   <= 1'b1;
      r_sclk  <= 1'b0;
      r_copi  <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != S_IDLE) begin
        r_div <= w_tc ? 9'd0 : r_div + 9'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_shift <= {req_addr, req_data};
            r_copi  <= req_rw;
            r_ncs   <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_div   <= '0;
            r_bits  <= '0;
            r_state <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (w_tc) begin
            r_sclk  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (w_tc) begin
            r_sclk <= ~r_sclk;
            // sclk currently high means this toggle is a fall: present the
            // next bit now so it is settled long before the following rise.
            if (r_sclk) begin
              r_copi  <= r_shift[14];
              r_shift <= {r_shift[13:0], 1'b0};
              r_bits  <= r_bits + 5'd1;
              if (r_bits == 5'd15) begin
                r_state <= S_HOLD;
              end
            end
          end
        end

        S_HOLD: begin
          if (w_tc) begin
            r_ncs   <= 1'b1;
            r_copi  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_GAP;
          end
        end

        S_GAP: begin
          if (w_tc) begin
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_div   <= '0;
          r_ncs   <= 1'b1;
          r_sclk  <= 1'b0;
          r_copi  <= 1'b0;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_ready;
  assign ncs       = r_ncs;
  assign sclk      = r_sclk;
  assign copi      = r_copi;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_spi_ctrl_writer.sv
// Directed bench for spi_ctrl_writer: one instance with CLK_DIV=4 and one with
// CLK_DIV=1, plus an SPI monitor that samples copi on each sclk rise.
module tb_spi_ctrl_writer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       req_rw = 1'b0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic       v4 = 1'b0;
  logic       v1 = 1'b0;

  logic ready4, ncs4, sclk4, copi4, busy4, done4;
  logic ready1, ncs1, sclk1, copi1, busy1, done1;

  spi_ctrl_writer #(.CLK_DIV(4)) u_dut4 (
    .clk(clk), .rst(rst), .req_valid(v4), .req_ready(ready4),
    .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
    .ncs(ncs4), .sclk(sclk4), .copi(copi4), .busy(busy4), .done(done4)
  );

  spi_ctrl_writer #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(ready1),
    .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
    .ncs(ncs1), .sclk(sclk1), .copi(copi1), .busy(busy1), .done(done1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor (index 0 = CLK_DIV 4, index 1 = CLK_DIV 1)
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0] m_ncs, m_sclk, m_copi, m_done, m_ready, m_valid;
  assign m_ncs   = {ncs1, ncs4};
  assign m_sclk  = {sclk1, sclk4};
  assign m_copi  = {copi1, copi4};
  assign m_done  = {done1, done4};
  assign m_ready = {ready1, ready4};
  assign m_valid = {v1, v4};

  int          hs_cyc[2];
  int          rises[2];
  int          rise_log[2][512];
  logic [47:0] cap[2] = '{default: '0};
  int          ncs_low[2];
  int          done_cnt[2];
  int          done_cyc[2];
  int          stab_err[2];
  int          nfall[2];
  int          hi_log[2][64];
  int          hi_run[2];
  logic [1:0]  p_sclk = '0;
  logic [1:0]  p_copi = '0;
  logic [1:0]  p_ncs  = '1;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (m_valid[i] && m_ready[i]) hs_cyc[i] = cyc;
      if (!p_sclk[i] && m_sclk[i]) begin
        cap[i] = {cap[i][46:0], m_copi[i]};
        if (m_copi[i] != p_copi[i]) stab_err[i]++;
        if (rises[i] < 512) rise_log[i][rises[i]] = cyc;
        rises[i]++;
      end
      if (m_ncs[i]) begin
        hi_run[i]++;
      end else begin
        if (p_ncs[i]) begin
          if (nfall[i] < 64) hi_log[i][nfall[i]] = hi_run[i];
          nfall[i]++;
        end
        hi_run[i] = 0;
        ncs_low[i]++;
      end
      if (m_done[i]) begin
        done_cnt[i]++;
        done_cyc[i] = cyc;
      end
      p_sclk[i] = m_sclk[i];
      p_copi[i] = m_copi[i];
      p_ncs[i]  = m_ncs[i];
    end
  end

  // ---------------- helpers
  task automatic wait_ready(input int i, output int t);
    t = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (m_ready[i]) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check("ready_timeout", 0, 1);
  endtask

  task automatic run_frame(input int i, input logic rw, input logic [6:0] a,
                           input logic [7:0] d, output int hs, output int rdy);
    req_rw = rw; req_addr = a; req_data = d;
    @(posedge clk); #1;
    if (i == 0) v4 = 1'b1; else v1 = 1'b1;
    @(posedge clk); #1;
    v4 = 1'b0; v1 = 1'b0;
    hs = hs_cyc[i];
    wait_ready(i, rdy);
  endtask

  logic [7:0] b2b_data[3] = '{8'h11, 8'h22, 8'h33};

  initial begin
    int hs, rdy, b_r, b_l, b_d, b_s, b_f, bad, got;
    int hs_t[3];

    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outs4", {ncs4, sclk4, copi4, ready4, busy4, done4}, 6'b100100);
    check("rst_outs1", {ncs1, sclk1, copi1, ready1, busy1, done1}, 6'b100100);
    @(posedge clk); #1 rst = 1'b0;

    // single write 0x80F0
    b_r = rises[0]; b_l = ncs_low[0]; b_d = done_cnt[0];
    run_frame(0, 1'b1, 7'h00, 8'hF0, hs, rdy);
    check("a_rises", rises[0] - b_r, 16);
    check("a_frame", cap[0][15:0], 16'h80F0);
    check("a_ncs_low", ncs_low[0] - b_l, 132);
    check("a_done_cnt", done_cnt[0] - b_d, 1);
    check("a_done_at", done_cyc[0] - hs, 133);
    check("a_ready_at", rdy - hs, 141);
    check("a_rise0_at", rise_log[0][b_r] - hs, 5);
    check("a_rise15_at", rise_log[0][b_r + 15] - hs, 125);

    // frame packing 0x7FAA
    b_r = rises[0]; b_s = stab_err[0];
    run_frame(0, 1'b0, 7'h7F, 8'hAA, hs, rdy);
    check("b_rises", rises[0] - b_r, 16);
    check("b_frame", cap[0][15:0], 16'h7FAA);
    check("b_copi_stable", stab_err[0] - b_s, 0);

    // back-to-back with valid held
    b_r = rises[0]; b_d = done_cnt[0]; b_f = nfall[0];
    req_rw = 1'b1; req_addr = 7'h01; req_data = b2b_data[0];
    @(posedge clk); #1 v4 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      got = 0;
      hs_t[k] = 0;
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        if (ready4) begin
          hs_t[k] = cyc;
          got = 1;
          break;
        end
      end
      if (got == 0) check("b2b_hs_timeout", 0, 1);
      @(posedge clk); #1;
      if (k < 2) begin
        req_addr = 7'(k + 2);
        req_data = b2b_data[k + 1];
      end else begin
        v4 = 1'b0;
      end
    end
    wait_ready(0, rdy);
    check("b2b_spacing01", hs_t[1] - hs_t[0], 141);
    check("b2b_spacing12", hs_t[2] - hs_t[1], 141);
    check("b2b_done_cnt", done_cnt[0] - b_d, 3);
    check("b2b_rises", rises[0] - b_r, 48);
    check("b2b_frames", cap[0], 48'h8111_8222_8333);
    check("b2b_gap1_ge8", hi_log[0][b_f + 1] >= 8, 1);
    check("b2b_gap2_ge8", hi_log[0][b_f + 2] >= 8, 1);

    // reset mid-frame after the 5th rise
    b_r = rises[0]; b_d = done_cnt[0];
    req_rw = 1'b1; req_addr = 7'h12; req_data = 8'h34;
    @(posedge clk); #1 v4 = 1'b1;
    @(posedge clk); #1 v4 = 1'b0;
    got = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); #1;
      if (rises[0] - b_r >= 5) begin
        got = 1;
        break;
      end
    end
    if (got == 0) check("abort_rise_timeout", 0, 1);
    check("abort_busy_before", {busy4, ready4, ncs4}, 3'b100);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_outs", {ncs4, sclk4, copi4, ready4, busy4, done4}, 6'b100100);
    repeat (150) @(negedge clk);
    check("abort_no_done", done_cnt[0] - b_d, 0);
    b_r = rises[0];
    run_frame(0, 1'b1, 7'h04, 8'h55, hs, rdy);
    check("abort_next_frame", cap[0][15:0], 16'h8455);
    check("abort_next_rises", rises[0] - b_r, 16);
    check("abort_next_done", done_cyc[0] - hs, 133);

    // reset wins over a simultaneous handshake
    @(posedge clk); #1 rst = 1'b1; v4 = 1'b1;
    @(posedge clk); #1 rst = 1'b0; v4 = 1'b0;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if ({ncs4, ready4, busy4} != 3'b110) bad++;
    end
    check("rst_vs_hs_idle", bad, 0);

    // CLK_DIV = 1 instance, write 0x8133
    b_r = rises[1]; b_d = done_cnt[1];
    run_frame(1, 1'b1, 7'h01, 8'h33, hs, rdy);
    check("d1_rises", rises[1] - b_r, 16);
    check("d1_frame", cap[1][15:0], 16'h8133);
    bad = 0;
    for (int k = 0; k < 16; k++)
      if (rise_log[1][b_r + k] - hs != 2 * k + 2) bad++;
    check("d1_rise_times", bad, 0);
    check("d1_done_at", done_cyc[1] - hs, 34);
    check("d1_done_cnt", done_cnt[1] - b_d, 1);
    check("d1_ready_at", rdy - hs, 36);

    // idle stability with changing request fields
    b_d = done_cnt[0] + done_cnt[1];
    bad = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      req_addr = 7'($urandom);
      req_data = 8'($urandom);
      req_rw   = 1'($urandom);
      @(negedge clk);
      if ({ncs4, sclk4, copi4, ready4, busy4, done4} != 6'b100100) bad++;
      if ({ncs1, sclk1, copi1, ready1, busy1, done1} != 6'b100100) bad++;
    end
    check("idle_outputs", bad, 0);
    check("idle_no_done", done_cnt[0] + done_cnt[1] - b_d, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

endmodule
